// File: rtl/display_pkg.sv
// Shared definitions for the 4-digit 7-segment display scan logic.
// Scan-state encoding, digit count, anode-off pattern and the leading-zero mask helper.
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DEAD = 2'd1,
    ST_ON   = 2'd2
  } scan_state_t;

  localparam int NUM_DIGITS = 4;
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

  // Digit i (i >= 1) is blankable when it and every more significant nibble are zero.
  function automatic logic [NUM_DIGITS-1:0] lz_blank_mask(
    input logic [4*NUM_DIGITS-1:0] value
  );
    logic [NUM_DIGITS-1:0] mask;
    logic                  zero_above;
    mask       = '0;
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (value[4*i +: 4] == 4'd0);
      mask[i]    = zero_above;
    end
    return mask;
  endfunction

endpackage

// File: rtl/scan_slot_timer.sv
// Per-digit slot timer: counts 0..PRESCALE-1 while run is high and flags the
// last dead-time cycle and the last cycle of the slot.
module scan_slot_timer #(
  parameter int PRESCALE    = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  output logic dead_end,
  output logic slot_end
);

  localparam int CW = $clog2(PRESCALE);
  localparam logic [CW-1:0] SLOT_LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;

  assign slot_end = run && (cnt_q == SLOT_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!run || slot_end) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // With no dead time the slot opens directly in ON, so there is no dead boundary to flag.
  generate
    if (DEAD_CYCLES == 0) begin : g_no_dead
      assign dead_end = 1'b0;
    end else begin : g_dead
      localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD_CYCLES - 1);
      assign dead_end = run && (cnt_q == DEAD_LAST);
    end
  endgenerate

endmodule

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit 7-segment display with
// frame-synchronous double buffering, anode dead-time and leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int PRESCALE    = 100000,
  parameter int DEAD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value_in,
  input  logic        value_load,
  input  logic        disp_en,
  input  logic        blank_lz,
  output logic [3:0]  nib0,
  output logic [3:0]  nib1,
  output logic [3:0]  nib2,
  output logic [3:0]  nib3,
  output logic [1:0]  sel,
  output logic [3:0]  an_n,
  output logic        load_ack,
  output logic        frame_done
);

  localparam scan_state_t SLOT_START = (DEAD_CYCLES == 0) ? ST_ON : ST_DEAD;
  localparam logic [1:0]  LAST_DIGIT = 2'(NUM_DIGITS - 1);

  scan_state_t state_q, state_d;
  logic [1:0]  sel_q, sel_d;
  logic [3:0]  an_n_q, an_n_d;
  logic [15:0] active_q, active_d;
  logic [15:0] shadow_q, shadow_d;
  logic        pending_q, pending_d;
  logic        load_ack_q, load_ack_d;
  logic        frame_done_q, frame_done_d;
  logic        commit;
  logic        run;
  logic        dead_end;
  logic        slot_end;
  logic [NUM_DIGITS-1:0] blank_mask;

  assign run = disp_en && (state_q != ST_IDLE);

  scan_slot_timer #(
    .PRESCALE    (PRESCALE),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .dead_end (dead_end),
    .slot_end (slot_end)
  );

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    frame_done_d = 1'b0;
    if (!disp_en) begin
      state_d = ST_IDLE;
      sel_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          state_d = SLOT_START;
          sel_d   = '0;
        end
        ST_DEAD: begin
          if (dead_end) state_d = ST_ON;
        end
        ST_ON: begin
          if (slot_end) begin
            state_d      = SLOT_START;
            sel_d        = sel_q + 2'd1;
            frame_done_d = (sel_q == LAST_DIGIT);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Commit only at a frame boundary or while dark, so a frame never mixes two values.
  assign commit = frame_done_d || ((state_q == ST_IDLE) && pending_q);

  always_comb begin
    active_d   = active_q;
    shadow_d   = shadow_q;
    pending_d  = pending_q;
    load_ack_d = 1'b0;
    if (value_load) shadow_d = value_in;
    if (commit && (pending_q || value_load)) begin
      active_d   = value_load ? value_in : shadow_q;
      pending_d  = 1'b0;
      load_ack_d = 1'b1;
    end else if (value_load) begin
      pending_d = 1'b1;
    end
  end

  // Mask follows the value that will be active, so it flips only together with a commit.
  assign blank_mask = blank_lz ? lz_blank_mask(active_d) : '0;

  always_comb begin
    an_n_d = ANODE_OFF;
    if ((state_d == ST_ON) && !blank_mask[sel_d]) an_n_d[sel_d] = 1'b0;
  end

  // NOTE: display buffers are ordinary flops, so they take the async reset too; a
  // reset therefore also drops any pending load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      an_n_q       <= ANODE_OFF;
      active_q     <= '0;
      shadow_q     <= '0;
      pending_q    <= 1'b0;
      load_ack_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      an_n_q       <= an_n_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      load_ack_q   <= load_ack_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign nib0       = active_q[3:0];
  assign nib1       = active_q[7:4];
  assign nib2       = active_q[11:8];
  assign nib3       = active_q[15:12];
  assign sel        = sel_q;
  assign an_n       = an_n_q;
  assign load_ack   = load_ack_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Directed self-checking bench for display_scan_ctrl with PRESCALE=8, DEAD_CYCLES=2.
// k is the 1-based cycle index since the scan entered DEAD of digit 0.
module tb_display_scan_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] value_in;
  logic        value_load;
  logic        disp_en;
  logic        blank_lz;
  logic [3:0]  nib0, nib1, nib2, nib3;
  logic [1:0]  sel;
  logic [3:0]  an_n;
  logic        load_ack;
  logic        frame_done;

  int errors = 0;
  int checks = 0;
  int k      = 0;

  display_scan_ctrl #(.PRESCALE(8), .DEAD_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .value_in   (value_in),
    .value_load (value_load),
    .disp_en    (disp_en),
    .blank_lz   (blank_lz),
    .nib0       (nib0),
    .nib1       (nib1),
    .nib2       (nib2),
    .nib3       (nib3),
    .sel        (sel),
    .an_n       (an_n),
    .load_ack   (load_ack),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  task automatic restart();
    disp_en = 1'b0;
    tick();
    disp_en = 1'b1;
    tick();
    k = 1;
  endtask

  task automatic load_pulse(input logic [15:0] v);
    value_in   = v;
    value_load = 1'b1;
    tick();
    value_load = 1'b0;
  endtask

  // Load while dark: capture on one edge, commit on the next.
  task automatic load_idle(input logic [15:0] v);
    disp_en = 1'b0;
    load_pulse(v);
    tick();
  endtask

  function automatic logic [3:0] exp_an(input int kk, input logic [15:0] val, input logic blk);
    int pos;
    int s;
    pos = (kk - 1) % 8;
    s   = ((kk - 1) / 8) % 4;
    if (pos < 2) return 4'hF;
    if (blk && s >= 1 && (val >> (4 * s)) == 16'd0) return 4'hF;
    return ~(4'b0001 << s);
  endfunction

  task automatic check_frame(input string name, input logic [15:0] val, input logic blk,
                             input int n);
    logic [3:0] ea;
    logic [1:0] es;
    logic       ef;
    for (int i = 0; i < n; i++) begin
      ea = exp_an(k, val, blk);
      es = 2'(((k - 1) / 8) % 4);
      ef = (k > 1) && (((k - 1) % 32) == 0);
      checks++;
      if (an_n !== ea || sel !== es || frame_done !== ef) begin
        errors++;
        $display("FAIL %s k=%0d: an_n=%b sel=%0d frame_done=%b, expected an_n=%b sel=%0d frame_done=%b",
                 name, k, an_n, sel, frame_done, ea, es, ef);
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; disp_en = 1'b0; blank_lz = 1'b0; value_load = 1'b0; value_in = '0;
    #12;
    checks++;
    if (an_n !== 4'hF || sel !== 2'd0 || {nib3, nib2, nib1, nib0} !== 16'h0 ||
        load_ack !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: an_n=%b sel=%0d nibs=%h ack=%b fd=%b, expected 1111 0 0000 0 0",
               an_n, sel, {nib3, nib2, nib1, nib0}, load_ack, frame_done);
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if (an_n !== 4'hF || sel !== 2'd0) begin
      errors++;
      $display("FAIL idle_dark: an_n=%b sel=%0d, expected 1111 0", an_n, sel);
    end
  endtask

  task automatic test_scan();
    disp_en = 1'b1;
    tick();
    k = 1;
    check_frame("scan", 16'h0000, 1'b0, 72);
  endtask

  task automatic test_load();
    restart();
    while (k < 10) tick();
    load_pulse(16'h1234);
    while (k < 33) begin
      checks++;
      if ({nib3, nib2, nib1, nib0} !== 16'h0000 || load_ack !== 1'b0) begin
        errors++;
        $display("FAIL load_early k=%0d: nibs=%h ack=%b, expected 0000 0",
                 k, {nib3, nib2, nib1, nib0}, load_ack);
      end
      tick();
    end
    checks++;
    if ({nib3, nib2, nib1, nib0} !== 16'h1234 || load_ack !== 1'b1 || frame_done !== 1'b1) begin
      errors++;
      $display("FAIL load_commit: nibs=%h ack=%b fd=%b, expected 1234 1 1",
               {nib3, nib2, nib1, nib0}, load_ack, frame_done);
    end
    tick();
    checks++;
    if (load_ack !== 1'b0) begin
      errors++;
      $display("FAIL load_ack_width: ack=%b, expected 0", load_ack);
    end
  endtask

  task automatic test_back_to_back();
    int acks = 0;
    int ack_k = 0;
    restart();
    while (k < 5) tick();
    load_pulse(16'hAAAA);
    while (k < 12) tick();
    load_pulse(16'h5555);
    while (k <= 40) begin
      if (load_ack === 1'b1) begin
        acks++;
        ack_k = k;
      end
      tick();
    end
    checks++;
    if (acks != 1 || ack_k != 33) begin
      errors++;
      $display("FAIL b2b_ack: acks=%0d at k=%0d, expected 1 at k=33", acks, ack_k);
    end
    checks++;
    if ({nib3, nib2, nib1, nib0} !== 16'h5555) begin
      errors++;
      $display("FAIL b2b_value: nibs=%h, expected 5555", {nib3, nib2, nib1, nib0});
    end
  endtask

  task automatic test_blank();
    logic [15:0] vals [2];
    vals[0] = 16'h0070;
    vals[1] = 16'h0000;
    blank_lz = 1'b1;
    for (int v = 0; v < 2; v++) begin
      load_idle(vals[v]);
      checks++;
      if ({nib3, nib2, nib1, nib0} !== vals[v] || load_ack !== 1'b1 || an_n !== 4'hF) begin
        errors++;
        $display("FAIL idle_commit: nibs=%h ack=%b an_n=%b, expected %h 1 1111",
                 {nib3, nib2, nib1, nib0}, load_ack, an_n, vals[v]);
      end
      disp_en = 1'b1;
      tick();
      k = 1;
      check_frame(v == 0 ? "blank_0070" : "blank_0000", vals[v], 1'b1, 33);
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_disable();
    restart();
    while (k < 20) tick();
    checks++;
    if (an_n !== 4'b1011 || sel !== 2'd2) begin
      errors++;
      $display("FAIL dis_pre: an_n=%b sel=%0d, expected 1011 2", an_n, sel);
    end
    disp_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (an_n !== 4'hF || sel !== 2'd0 || frame_done !== 1'b0) begin
        errors++;
        $display("FAIL dis_dark %0d: an_n=%b sel=%0d fd=%b, expected 1111 0 0",
                 i, an_n, sel, frame_done);
      end
    end
    disp_en = 1'b1;
    tick();
    k = 1;
    check_frame("reenable", 16'h0000, 1'b0, 16);
  endtask

  task automatic test_reset_mid();
    int acks = 0;
    load_idle(16'h4321);
    checks++;
    if ({nib3, nib2, nib1, nib0} !== 16'h4321) begin
      errors++;
      $display("FAIL rst_preload: nibs=%h, expected 4321", {nib3, nib2, nib1, nib0});
    end
    disp_en = 1'b1;
    tick();
    k = 1;
    while (k < 12) tick();
    load_pulse(16'h9999);
    while (k < 14) tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if (an_n !== 4'hF || sel !== 2'd0) begin
      errors++;
      $display("FAIL rst_async: an_n=%b sel=%0d, expected 1111 0", an_n, sel);
    end
    #2;
    rst_n = 1'b1;
    tick();
    k = 1;
    checks++;
    if ({nib3, nib2, nib1, nib0} !== 16'h0000) begin
      errors++;
      $display("FAIL rst_active: nibs=%h, expected 0000", {nib3, nib2, nib1, nib0});
    end
    for (int i = 0; i < 40; i++) begin
      if (load_ack === 1'b1) acks++;
      tick();
    end
    checks++;
    if (acks != 0 || {nib3, nib2, nib1, nib0} !== 16'h0000) begin
      errors++;
      $display("FAIL rst_pending: acks=%0d nibs=%h, expected 0 0000",
               acks, {nib3, nib2, nib1, nib0});
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_load();
    test_back_to_back();
    test_blank();
    test_disable();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
